// File: rtl/cache_nway.sv
`default_nettype none
// ============================================================================
// Module   : cache_nway
// Brief    : N-way set-associative write-back / write-allocate L1 cache, one
//            outstanding request, flop-array storage.
// Options  : define CACHE_PLRU_EN for tree pseudo-LRU replacement (else LFSR)
// Revision : 1.0 - initial release
// ============================================================================
module cache_nway #(
    parameter int WAYS  = 2,
    parameter int IDX_W = 8,
    parameter int OFS_W = 4
) (
    input  logic                             clk,
    input  logic                             resetn,
    input  logic                             valid,
    input  logic                             op,
    input  logic [IDX_W-1:0]                 index,
    input  logic [31-IDX_W-OFS_W:0]          tag,
    input  logic [OFS_W-1:0]                 offset,
    input  logic [3:0]                       wstrb,
    input  logic [31:0]                      wdata,
    output logic                             addr_ok,
    output logic                             data_ok,
    output logic [31:0]                      rdata,
    output logic                             rd_req,
    output logic [2:0]                       rd_type,
    output logic [31:0]                      rd_addr,
    input  logic                             rd_rdy,
    input  logic                             ret_valid,
    input  logic                             ret_last,
    input  logic [31:0]                      ret_data,
    output logic                             wr_req,
    output logic [2:0]                       wr_type,
    output logic [31:0]                      wr_addr,
    output logic [3:0]                       wr_wstrb,
    output logic [32*(2**(OFS_W-2))-1:0]     wr_data,
    input  logic                             wr_rdy
);
    localparam int TAG_W = 32 - IDX_W - OFS_W;
    localparam int SETS  = 2**IDX_W;
    localparam int WORDS = 2**(OFS_W-2);
    localparam int WRD_W = OFS_W - 2;
    localparam int WAY_W = (WAYS > 1) ? $clog2(WAYS) : 1;
    localparam int LVLS  = $clog2(WAYS);

    typedef enum logic [2:0] {S_IDLE, S_LOOKUP, S_MISS, S_REPLACE, S_REFILL} state_t;

    state_t             state_q;
    logic               op_q, rd_req_q, wr_req_q;
    logic [TAG_W-1:0]   req_tag_q;
    logic [IDX_W-1:0]   idx_q;
    logic [WRD_W-1:0]   word_q, cnt_q;
    logic [3:0]         wstrb_q;
    logic [31:0]        wdata_q;
    logic [WAY_W-1:0]   vic_way_q;

    logic [WAYS-1:0]    valid_q [SETS];
    logic [WAYS-1:0]    dirty_q [SETS];
    logic [TAG_W-1:0]   tag_q   [WAYS][SETS];
    logic [31:0]        data_q  [WAYS][SETS][WORDS];

    logic               w_hit, w_inv_found, w_beat_hit, w_unused;
    logic [WAY_W-1:0]   w_hit_way, w_inv_way, w_pol_way, w_vic_way_d;
    logic [31:0]        w_hit_word, w_fill_word;

    function automatic logic [31:0] merge(input logic [31:0] o, input logic [31:0] n,
                                          input logic [3:0] s);
        for (int b = 0; b < 4; b++)
            if (s[b]) o[8*b +: 8] = n[8*b +: 8];
        return o;
    endfunction

`ifdef CACHE_PLRU_EN
    localparam int PL_W = (WAYS > 1) ? WAYS - 1 : 1;
    logic [PL_W-1:0] plru_q [SETS];

    // Heap-ordered tree: node n lives in bit n-1, a bit value names the LRU child.
    function automatic logic [WAY_W-1:0] plru_pick(input logic [PL_W-1:0] b);
        int node;
        node = 1;
        for (int l = 0; l < LVLS; l++) node = 2*node + int'(b[node-1]);
        return WAY_W'(node - WAYS);
    endfunction

    function automatic logic [PL_W-1:0] plru_touch(input logic [PL_W-1:0] b,
                                                   input logic [WAY_W-1:0] w);
        int   node;
        logic dir;
        node = 1;
        for (int l = 0; l < LVLS; l++) begin
            dir         = w[LVLS-1-l];
            b[node-1]   = ~dir;
            node        = 2*node + int'(dir);
        end
        return b;
    endfunction

    assign w_pol_way = plru_pick(plru_q[idx_q]);
`else
    logic [15:0] lfsr_q;
    assign w_pol_way = (WAYS > 1) ? lfsr_q[WAY_W-1:0] : '0;
`endif

    always_comb begin
        w_hit       = 1'b0;
        w_hit_way   = '0;
        w_inv_found = 1'b0;
        w_inv_way   = '0;
        for (int w = 0; w < WAYS; w++) begin
            if (valid_q[idx_q][w] && (tag_q[w][idx_q] == req_tag_q)) begin
                w_hit     = 1'b1;
                w_hit_way = WAY_W'(w);
            end
        end
        for (int w = WAYS - 1; w >= 0; w--) begin
            if (!valid_q[idx_q][w]) begin
                w_inv_found = 1'b1;
                w_inv_way   = WAY_W'(w);
            end
        end
        w_vic_way_d = w_inv_found ? w_inv_way : w_pol_way;
    end

    assign w_hit_word  = data_q[w_hit_way][idx_q][word_q];
    assign w_beat_hit  = (state_q == S_REFILL) && ret_valid && (cnt_q == word_q);
    assign w_fill_word = (op_q && (cnt_q == word_q)) ? merge(ret_data, wdata_q, wstrb_q) : ret_data;
    assign w_unused    = ^offset[1:0];

    assign addr_ok  = resetn && (state_q == S_IDLE);
    assign data_ok  = ((state_q == S_LOOKUP) && w_hit) || w_beat_hit;
    assign rdata    = op_q ? 32'h0 :
                      ((state_q == S_LOOKUP) && w_hit) ? w_hit_word :
                      w_beat_hit ? ret_data : 32'h0;
    assign rd_req   = rd_req_q;
    assign rd_type  = 3'b100;
    assign rd_addr  = {req_tag_q, idx_q, {OFS_W{1'b0}}};
    assign wr_req   = wr_req_q;
    assign wr_type  = 3'b100;
    assign wr_wstrb = 4'hf;
    assign wr_addr  = {tag_q[vic_way_q][idx_q], idx_q, {OFS_W{1'b0}}};

    always_comb begin
        wr_data = '0;
        for (int i = 0; i < WORDS; i++) wr_data[32*i +: 32] = data_q[vic_way_q][idx_q][i];
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q   <= S_IDLE;
            op_q      <= 1'b0;
            rd_req_q  <= 1'b0;
            wr_req_q  <= 1'b0;
            req_tag_q <= '0;
            idx_q     <= '0;
            word_q    <= '0;
            cnt_q     <= '0;
            wstrb_q   <= '0;
            wdata_q   <= '0;
            vic_way_q <= '0;
            for (int s = 0; s < SETS; s++) begin
                valid_q[s] <= '0;
                dirty_q[s] <= '0;
`ifdef CACHE_PLRU_EN
                plru_q[s]  <= '0;
`endif
            end
`ifndef CACHE_PLRU_EN
            lfsr_q    <= 16'h0001;
`endif
        end else begin
`ifndef CACHE_PLRU_EN
            lfsr_q <= {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
`endif
            case (state_q)
                S_IDLE: begin
                    if (valid) begin
                        op_q      <= op;
                        req_tag_q <= tag;
                        idx_q     <= index;
                        word_q    <= offset[OFS_W-1:2];
                        wstrb_q   <= wstrb;
                        wdata_q   <= wdata;
                        state_q   <= S_LOOKUP;
                    end
                end
                S_LOOKUP: begin
                    if (w_hit) begin
                        if (op_q) dirty_q[idx_q][w_hit_way] <= 1'b1;
`ifdef CACHE_PLRU_EN
                        plru_q[idx_q] <= plru_touch(plru_q[idx_q], w_hit_way);
`endif
                        state_q <= S_IDLE;
                    end else begin
                        vic_way_q <= w_vic_way_d;
                        wr_req_q  <= valid_q[idx_q][w_vic_way_d] && dirty_q[idx_q][w_vic_way_d];
                        state_q   <= S_MISS;
                    end
                end
                S_MISS: begin
                    if (!wr_req_q || wr_rdy) begin
                        wr_req_q <= 1'b0;
                        rd_req_q <= 1'b1;
                        state_q  <= S_REPLACE;
                    end
                end
                S_REPLACE: begin
                    if (rd_rdy) begin
                        rd_req_q <= 1'b0;
                        state_q  <= S_REFILL;
                    end
                end
                S_REFILL: begin
                    if (ret_valid) begin
                        if (ret_last) begin
                            cnt_q                     <= '0;
                            valid_q[idx_q][vic_way_q] <= 1'b1;
                            dirty_q[idx_q][vic_way_q] <= op_q;
`ifdef CACHE_PLRU_EN
                            plru_q[idx_q] <= plru_touch(plru_q[idx_q], vic_way_q);
`endif
                            state_q <= S_IDLE;
                        end else begin
                            cnt_q <= cnt_q + 1'b1;
                        end
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    // Payload storage needs no reset: valid bits gate every use of it.
    always_ff @(posedge clk) begin
        if ((state_q == S_LOOKUP) && w_hit && op_q)
            data_q[w_hit_way][idx_q][word_q] <= merge(w_hit_word, wdata_q, wstrb_q);
        if ((state_q == S_REFILL) && ret_valid) begin
            data_q[vic_way_q][idx_q][cnt_q] <= w_fill_word;
            if (ret_last) tag_q[vic_way_q][idx_q] <= req_tag_q;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_cache_nway.sv
`default_nettype none
// ============================================================================
// Module   : tb_cache_nway
// Brief    : Directed self-checking bench for cache_nway (WAYS=2, IDX_W=8, OFS_W=4)
// Revision : 1.0 - initial release
// ============================================================================
module tb_cache_nway;
    logic         clk = 1'b0;
    logic         resetn, valid, op, rd_rdy, ret_valid, ret_last, wr_rdy;
    logic [7:0]   index;
    logic [19:0]  tag;
    logic [3:0]   offset, wstrb, wr_wstrb;
    logic [31:0]  wdata, rdata, rd_addr, ret_data, wr_addr;
    logic         addr_ok, data_ok, rd_req, wr_req;
    logic [2:0]   rd_type, wr_type;
    logic [127:0] wr_data;

    always #5 clk = ~clk;

    cache_nway #(.WAYS(2), .IDX_W(8), .OFS_W(4)) u_dut (
        .clk(clk), .resetn(resetn), .valid(valid), .op(op), .index(index), .tag(tag),
        .offset(offset), .wstrb(wstrb), .wdata(wdata), .addr_ok(addr_ok), .data_ok(data_ok),
        .rdata(rdata), .rd_req(rd_req), .rd_type(rd_type), .rd_addr(rd_addr), .rd_rdy(rd_rdy),
        .ret_valid(ret_valid), .ret_last(ret_last), .ret_data(ret_data), .wr_req(wr_req),
        .wr_type(wr_type), .wr_addr(wr_addr), .wr_wstrb(wr_wstrb), .wr_data(wr_data),
        .wr_rdy(wr_rdy)
    );

    int n_cmp = 0;
    int n_bad = 0;
    int wb_cnt = 0;
    logic        seen5;
    logic [31:0] wb5_word2;

    // Shadow of set 0 only; every access in this bench targets index 0.
    logic         sh_valid [2];
    logic         sh_dirty [2];
    logic [19:0]  sh_tag   [2];
    logic [127:0] sh_line  [2];
    logic         sh_plru;
    logic [15:0]  lfsr_m;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) lfsr_m <= 16'h0001;
        else         lfsr_m <= {lfsr_m[14:0], lfsr_m[15] ^ lfsr_m[13] ^ lfsr_m[12] ^ lfsr_m[10]};
    end

    task automatic check_eq(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] merge(input logic [31:0] o, input logic [31:0] n,
                                          input logic [3:0] s);
        for (int b = 0; b < 4; b++)
            if (s[b]) o[8*b +: 8] = n[8*b +: 8];
        return o;
    endfunction

    // Memory image served by the bench: line of tag 1 is 0x11111111..0x44444444.
    function automatic logic [31:0] beat(input logic [19:0] t, input int i);
        logic [7:0] hi;
        hi = t[7:0] - 8'd1;
        return (32'h11111111 * 32'(i + 1)) ^ {hi, 24'h0};
    endfunction

    task automatic clear_shadow();
        for (int w = 0; w < 2; w++) begin
            sh_valid[w] = 1'b0;
            sh_dirty[w] = 1'b0;
            sh_tag[w]   = '0;
            sh_line[w]  = '0;
        end
        sh_plru = 1'b0;
    endtask

    task automatic access(input string nm, input logic wr, input logic [31:0] addr,
                          input logic [3:0] strb, input logic [31:0] wd, input logic [31:0] exp_rd);
        logic [19:0]  t;
        logic [1:0]   wi;
        logic         hit, wb;
        int           hw, vw;
        logic [31:0]  mw;
        logic [127:0] line;
        t   = addr[31:12];
        wi  = addr[3:2];
        hit = 1'b0;
        hw  = 0;
        for (int w = 0; w < 2; w++)
            if (sh_valid[w] && sh_tag[w] == t) begin hit = 1'b1; hw = w; end
        valid = 1'b1; op = wr; tag = t; index = addr[11:4]; offset = addr[3:0];
        wstrb = strb; wdata = wd;
        @(negedge clk);
        check_eq({nm, " addr_ok"}, addr_ok, 1'b1);
        step();
        valid = 1'b0;
        if (!sh_valid[0]) vw = 0;
        else if (!sh_valid[1]) vw = 1;
`ifdef CACHE_PLRU_EN
        else vw = int'(sh_plru);
`else
        else vw = int'(lfsr_m[0]);
`endif
        @(negedge clk);
        check_eq({nm, " lookup data_ok"}, data_ok, hit);
        if (!wr) check_eq({nm, " lookup rdata"}, rdata, hit ? exp_rd : 32'h0);
        if (hit) begin
            if (wr) begin
                sh_line[hw][32*wi +: 32] = merge(sh_line[hw][32*wi +: 32], wd, strb);
                sh_dirty[hw] = 1'b1;
            end
            sh_plru = (hw == 0);
            step();
            return;
        end
        step();
        @(negedge clk);
        wb = sh_valid[vw] && sh_dirty[vw];
        check_eq({nm, " wr_req"}, wr_req, wb);
        if (wb) begin
            wb_cnt++;
            check_eq({nm, " wr_addr"}, wr_addr, {sh_tag[vw], 12'h000});
            check_eq({nm, " wr_data"}, wr_data, sh_line[vw]);
            if (sh_tag[vw] == 20'h5) begin
                seen5     = 1'b1;
                wb5_word2 = wr_data[95:64];
            end
            step();
            @(negedge clk);
            check_eq({nm, " wr_req held"}, {wr_req, wr_addr}, {1'b1, sh_tag[vw], 12'h000});
            wr_rdy = 1'b1;
            step();
            wr_rdy = 1'b0;
        end else begin
            step();
        end
        @(negedge clk);
        check_eq({nm, " rd_req"}, rd_req, 1'b1);
        check_eq({nm, " rd_addr"}, rd_addr, {addr[31:4], 4'h0});
        step();
        @(negedge clk);
        check_eq({nm, " rd_req held"}, rd_req, 1'b1);
        rd_rdy = 1'b1;
        step();
        rd_rdy = 1'b0;
        line = '0;
        for (int i = 0; i < 4; i++) begin
            ret_valid = 1'b1;
            ret_last  = (i == 3);
            ret_data  = beat(t, i);
            mw = ret_data;
            if (wr && i == int'(wi)) mw = merge(mw, wd, strb);
            line[32*i +: 32] = mw;
            @(negedge clk);
            check_eq({nm, " beat data_ok"}, data_ok, (i == int'(wi)));
            if (!wr && i == int'(wi)) check_eq({nm, " refill rdata"}, rdata, exp_rd);
            step();
        end
        ret_valid = 1'b0;
        ret_last  = 1'b0;
        sh_valid[vw] = 1'b1;
        sh_tag[vw]   = t;
        sh_dirty[vw] = wr;
        sh_line[vw]  = line;
        sh_plru      = (vw == 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int wb_before;
        logic [19:0] tk;
        resetn = 1'b1; valid = 1'b0; op = 1'b0; index = '0; tag = '0; offset = '0;
        wstrb = '0; wdata = '0; rd_rdy = 1'b0; ret_valid = 1'b0; ret_last = 1'b0;
        ret_data = '0; wr_rdy = 1'b0; seen5 = 1'b0; wb5_word2 = '0;
        clear_shadow();
        #2 resetn = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_eq("reset outs", {addr_ok, data_ok, rd_req, wr_req, rdata}, '0);
        check_eq("const types", {rd_type, wr_type, wr_wstrb}, {3'b100, 3'b100, 4'hf});
        step();
        resetn = 1'b1;
        @(negedge clk);
        check_eq("idle addr_ok", addr_ok, 1'b1);
        step();

        access("t1 cold rd", 1'b0, 32'h00001004, 4'h0, 32'h0, 32'h22222222);
        access("t1 re-rd",   1'b0, 32'h00001004, 4'h0, 32'h0, 32'h22222222);
        access("t2 wr hit",  1'b1, 32'h00001004, 4'b0011, 32'hAAAABBBB, 32'h0);
        access("t2 rd back", 1'b0, 32'h00001004, 4'h0, 32'h0, 32'h2222BBBB);

        access("t3 wr A", 1'b1, 32'h00001000, 4'hf, 32'h0A0A0A0A, 32'h0);
        access("t3 wr B", 1'b1, 32'h00002000, 4'hf, 32'h0B0B0B0B, 32'h0);
        wb_before = wb_cnt;
        access("t3 rd C", 1'b0, 32'h00003000, 4'h0, 32'h0, 32'h13111111);
        check_eq("t3 writeback count", wb_cnt - wb_before, 1);

        access("t4 wr miss", 1'b1, 32'h00005008, 4'hf, 32'hDEADBEEF, 32'h0);
        for (int k = 0; k < 16; k++) begin
            if (!seen5) begin
                tk = 20'h10 + 20'(k);
                access("t4 evict", 1'b0, {tk, 12'h000}, 4'h0, 32'h0, beat(tk, 0));
            end
        end
        check_eq("t4 line evicted", seen5, 1'b1);
        check_eq("t4 word2", wb5_word2, 32'hDEADBEEF);

        // Reset in the middle of a refill, then the same read must miss again.
        resetn = 1'b0;
        step();
        resetn = 1'b1;
        clear_shadow();
        step();
        valid = 1'b1; op = 1'b0; tag = 20'h1; index = 8'h0; offset = 4'h8;
        step();
        valid = 1'b0;
        step();
        step();
        @(negedge clk);
        check_eq("t5 rd_req", rd_req, 1'b1);
        rd_rdy = 1'b1;
        step();
        rd_rdy = 1'b0;
        for (int i = 0; i < 2; i++) begin
            ret_valid = 1'b1;
            ret_data  = beat(20'h1, i);
            step();
        end
        ret_data = beat(20'h1, 2);
        resetn   = 1'b0;
        #1;
        check_eq("t5 reset outs", {addr_ok, data_ok, rd_req, wr_req, rdata}, '0);
        ret_valid = 1'b0;
        step();
        resetn = 1'b1;
        step();
        access("t5 re-rd", 1'b0, 32'h00001008, 4'h0, 32'h0, 32'h33333333);

`ifdef CACHE_PLRU_EN
        resetn = 1'b0;
        step();
        resetn = 1'b1;
        clear_shadow();
        step();
        access("t6 A",       1'b0, 32'h00001000, 4'h0, 32'h0, 32'h11111111);
        access("t6 B",       1'b0, 32'h00002000, 4'h0, 32'h0, 32'h10111111);
        access("t6 A hit",   1'b0, 32'h00001000, 4'h0, 32'h0, 32'h11111111);
        access("t6 C",       1'b0, 32'h00003000, 4'h0, 32'h0, 32'h13111111);
        check_eq("t6 B evicted", {sh_tag[1], sh_tag[0]}, {20'h3, 20'h1});
        access("t6 A still", 1'b0, 32'h00001000, 4'h0, 32'h0, 32'h11111111);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
